// File: rtl/led_serializer.sv
// Parallel-to-serial driver for a 74HC595-style shift/latch chain.
// Accepts a word on valid/ready, clocks it out bit by bit, then pulses the latch.
module led_serializer #(
    parameter int N         = 8,
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         sys_rst_n,
    input  logic         valid,
    input  logic [N-1:0] data,
    output logic         ready,
    output logic         ser_data,
    output logic         ser_clk,
    output logic         ser_latch,
    output logic         done
);

    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(N);

    localparam logic [PW-1:0] PH_LAST    = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HIGH    = PW'(CLK_DIV);
    localparam logic [PW-1:0] LATCH_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic [N-1:0]  shadow, shadow_nxt;
    logic [BW-1:0] bit_idx;
    logic          ready_nxt, ser_data_nxt, ser_clk_nxt, ser_latch_nxt, done_nxt;

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        bit_nxt    = bit_cnt;
        shadow_nxt = shadow;

        case (state)
            S_IDLE: begin
                if (valid) begin
                    state_nxt  = S_SHIFT;
                    phase_nxt  = '0;
                    bit_nxt    = '0;
                    shadow_nxt = data;
                end
            end
            S_SHIFT: begin
                if (phase == PH_LAST) begin
                    phase_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = S_LATCH;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            S_LATCH: begin
                if (phase == LATCH_LAST) begin
                    state_nxt = S_DONE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt  = S_IDLE;
                bit_nxt    = '0;
                shadow_nxt = '0;
            end
            default: state_nxt = S_IDLE;
        endcase

        bit_idx       = (MSB_FIRST != 0) ? (BIT_LAST - bit_nxt) : bit_nxt;
        ser_data_nxt  = (state_nxt == S_SHIFT || state_nxt == S_LATCH) ? shadow_nxt[bit_idx] : 1'b0;
        ser_clk_nxt   = (state_nxt == S_SHIFT) && (phase_nxt >= PH_HIGH);
        ser_latch_nxt = (state_nxt == S_LATCH);
        done_nxt      = (state_nxt == S_DONE);
        ready_nxt     = (state_nxt == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            phase     <= '0;
            bit_cnt   <= '0;
            shadow    <= '0;
            ready     <= 1'b1;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            bit_cnt   <= bit_nxt;
            shadow    <= shadow_nxt;
            ready     <= ready_nxt;
            ser_data  <= ser_data_nxt;
            ser_clk   <= ser_clk_nxt;
            ser_latch <= ser_latch_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_led_serializer.sv
// Scoreboard bench for led_serializer: two configurations share clock and reset;
// accepted words are queued by a transfer-level model and checked by a monitor.
module tb_led_serializer;

    localparam int N0 = 8;
    localparam int C0 = 2;
    localparam int M0 = 1;
    localparam int N1 = 4;
    localparam int C1 = 1;
    localparam int M1 = 0;

    typedef struct {
        logic [7:0] data;
        int         cap;
    } exp_t;

    logic          clk = 1'b0;
    logic          sys_rst_n;
    logic          valid0, valid1;
    logic [N0-1:0] data0;
    logic [N1-1:0] data1;
    logic          ready0, ser_data0, ser_clk0, ser_latch0, done0;
    logic          ready1, ser_data1, ser_clk1, ser_latch1, done1;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   pc           = 0;
    logic s_rst;
    logic s_valid [2];
    logic [7:0] s_data [2];

    exp_t q0[$];
    exp_t q1[$];
    int   next_free [2];
    int   rises     [2];
    int   latch_cnt [2];
    int   last_done [2];
    int   done_gap  [2];
    logic [7:0] word_seen [2];
    logic prev_sc [2];
    logic prev_sl [2];

    always #5 clk = ~clk;

    led_serializer #(.N(N0), .CLK_DIV(C0), .MSB_FIRST(M0)) dut0 (
        .clk(clk), .sys_rst_n(sys_rst_n), .valid(valid0), .data(data0),
        .ready(ready0), .ser_data(ser_data0), .ser_clk(ser_clk0),
        .ser_latch(ser_latch0), .done(done0)
    );

    led_serializer #(.N(N1), .CLK_DIV(C1), .MSB_FIRST(M1)) dut1 (
        .clk(clk), .sys_rst_n(sys_rst_n), .valid(valid1), .data(data1),
        .ready(ready1), .ser_data(ser_data1), .ser_clk(ser_clk1),
        .ser_latch(ser_latch1), .done(done1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, pc, actual, expected);
        end
    endtask

    function automatic int unitN(input int u);
        return (u != 0) ? N1 : N0;
    endfunction

    function automatic int unitC(input int u);
        return (u != 0) ? C1 : C0;
    endfunction

    function automatic int unitM(input int u);
        return (u != 0) ? M1 : M0;
    endfunction

    function automatic int qsize(input int u);
        return (u != 0) ? q1.size() : q0.size();
    endfunction

    task automatic clearMonitor(input int u);
        rises[u]     = 0;
        latch_cnt[u] = 0;
        word_seen[u] = '0;
        prev_sc[u]   = 1'b0;
        prev_sl[u]   = 1'b0;
    endtask

    // Transfer-level model: a word is accepted when the unit has been idle long enough.
    task automatic modelStep(input int u);
        exp_t e;
        int   n, c;
        n = unitN(u);
        c = unitC(u);
        if (!s_rst) begin
            next_free[u] = pc + 1;
            if (u != 0) q1.delete(); else q0.delete();
            clearMonitor(u);
        end else if (s_valid[u] && pc >= next_free[u]) begin
            e.data = s_data[u];
            e.cap  = pc;
            if (u != 0) q1.push_back(e); else q0.push_back(e);
            next_free[u] = pc + 2 * c * n + c + 2;
        end
    endtask

    task automatic monitorUnit(input int u, input logic rdy, input logic sd, input logic sc,
                               input logic sl, input logic dn);
        exp_t e;
        int   n, c, mf, k, j, pos;
        n  = unitN(u);
        c  = unitC(u);
        mf = unitM(u);
        checkOutput($sformatf("u%0d_ready", u), 32'(rdy), 32'(pc + 1 >= next_free[u]));
        if (qsize(u) == 0) begin
            checkOutput($sformatf("u%0d_idle_outputs", u), 32'({sd, sc, sl, dn}), 32'd0);
        end else begin
            e = (u != 0) ? q1[0] : q0[0];
            k = pc - e.cap;
            checkOutput($sformatf("u%0d_latch_clk_overlap", u), 32'(sl & sc), 32'd0);
            if (sc && !prev_sc[u]) begin
                j = rises[u];
                if (j < n) begin
                    pos = (mf != 0) ? (n - 1 - j) : j;
                    checkOutput($sformatf("u%0d_bit%0d", u, j), 32'(sd), 32'(e.data[pos]));
                    word_seen[u][pos] = sd;
                end
                checkOutput($sformatf("u%0d_rise_time", u), 32'(k), 32'(2 * c * j + c));
                rises[u]++;
            end
            if (sl) begin
                if (!prev_sl[u]) begin
                    checkOutput($sformatf("u%0d_latch_time", u), 32'(k), 32'(2 * c * n));
                    checkOutput($sformatf("u%0d_latched_word", u), 32'(word_seen[u]), 32'(e.data));
                    checkOutput($sformatf("u%0d_rise_count", u), 32'(rises[u]), 32'(n));
                end
                checkOutput($sformatf("u%0d_latch_data", u), 32'(sd), 32'(e.data[(mf != 0) ? 0 : n - 1]));
                latch_cnt[u]++;
            end
            if (k == 2 * c * n + c) begin
                checkOutput($sformatf("u%0d_done_outputs", u), 32'({dn, sl, sc, sd}), 32'b1000);
                checkOutput($sformatf("u%0d_latch_len", u), 32'(latch_cnt[u]), 32'(c));
                done_gap[u]  = pc - last_done[u];
                last_done[u] = pc;
                if (u != 0) void'(q1.pop_front()); else void'(q0.pop_front());
                clearMonitor(u);
            end else if (dn) begin
                checkOutput($sformatf("u%0d_done_time", u), 32'(k), 32'(2 * c * n + c));
            end
        end
        prev_sc[u] = sc;
        prev_sl[u] = sl;
    endtask

    // Capture what the DUTs see at each active edge.
    initial begin
        forever begin
            @(posedge clk);
            pc         = pc + 1;
            s_rst      = sys_rst_n;
            s_valid[0] = valid0;
            s_valid[1] = valid1;
            s_data[0]  = data0;
            s_data[1]  = {4'b0000, data1};
        end
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            next_free[u] = 0;
            last_done[u] = 0;
            done_gap[u]  = 0;
            clearMonitor(u);
        end
        forever begin
            @(negedge clk);
            if (pc >= 1) begin
                modelStep(0);
                modelStep(1);
                monitorUnit(0, ready0, ser_data0, ser_clk0, ser_latch0, done0);
                monitorUnit(1, ready1, ser_data1, ser_clk1, ser_latch1, done1);
            end
        end
    end

    task automatic applyStimulus(input int u, input logic [7:0] word);
        @(negedge clk);
        if (u != 0) begin
            valid1 = 1'b1;
            data1  = word[3:0];
        end else begin
            valid0 = 1'b1;
            data0  = word;
        end
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
        data0  = 8'($urandom);
        data1  = 4'($urandom);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        valid0    = 1'b1;
        data0     = 8'hA5;
        valid1    = 1'b0;
        data1     = 4'b0000;
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b1;
        valid1    = 1'b1;
        data1     = 4'b0011;
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
        data0  = 8'($urandom);
        data1  = 4'($urandom);
        repeat (40) @(negedge clk);

        // A word offered while busy must be dropped.
        applyStimulus(0, 8'h00);
        repeat (4) @(negedge clk);
        valid0 = 1'b1;
        data0  = 8'hFF;
        @(negedge clk);
        valid0 = 1'b0;
        repeat (45) @(negedge clk);

        applyStimulus(0, 8'($urandom));
        repeat (12) @(negedge clk);
        sys_rst_n = 1'b0;
        @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge clk);
        applyStimulus(0, 8'h3C);
        repeat (40) @(negedge clk);

        @(negedge clk);
        valid0 = 1'b1;
        data0  = 8'h81;
        @(negedge clk);
        data0 = 8'h7E;
        repeat (36) @(negedge clk);
        valid0 = 1'b0;
        repeat (45) @(negedge clk);
        checkOutput("b2b_done_spacing", 32'(done_gap[0]), 32'(2 * C0 * N0 + C0 + 2));

        for (int i = 0; i < 30; i++) begin
            applyStimulus(int'($urandom_range(0, 1)), 8'($urandom));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        repeat (60) @(negedge clk);
        checkOutput("u0_pending_words", 32'(q0.size()), 32'd0);
        checkOutput("u1_pending_words", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
